// File: rtl/id_stage_pkg.sv
// Shared opcode/funct constants, reset PC and instruction classification for the ID stage.
package id_stage_pkg;

   localparam logic [5:0] SPECIAL = 6'h00;
   localparam logic [5:0] ORI     = 6'h0d;
   localparam logic [5:0] LUI     = 6'h0f;
   localparam logic [5:0] LW      = 6'h23;
   localparam logic [5:0] SW      = 6'h2b;
   localparam logic [5:0] BEQ     = 6'h04;
   localparam logic [5:0] BNE     = 6'h05;
   localparam logic [5:0] JAL     = 6'h03;

   localparam logic [5:0] ADDU    = 6'h21;
   localparam logic [5:0] SUBU    = 6'h23;
   localparam logic [5:0] JR      = 6'h08;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic [3:0] {
      INSTR_NOP,
      INSTR_ADDU,
      INSTR_SUBU,
      INSTR_ORI,
      INSTR_LUI,
      INSTR_LW,
      INSTR_SW,
      INSTR_BEQ,
      INSTR_BNE,
      INSTR_JAL,
      INSTR_JR
   } instr_e;

   // Anything outside the supported subset collapses to INSTR_NOP.
   function automatic instr_e decode_instr(input logic [5:0] op, input logic [5:0] funct);
      instr_e kind;
      kind = INSTR_NOP;
      case (op)
         SPECIAL: begin
            case (funct)
               ADDU:    kind = INSTR_ADDU;
               SUBU:    kind = INSTR_SUBU;
               JR:      kind = INSTR_JR;
               default: kind = INSTR_NOP;
            endcase
         end
         ORI:     kind = INSTR_ORI;
         LUI:     kind = INSTR_LUI;
         LW:      kind = INSTR_LW;
         SW:      kind = INSTR_SW;
         BEQ:     kind = INSTR_BEQ;
         BNE:     kind = INSTR_BNE;
         JAL:     kind = INSTR_JAL;
         default: kind = INSTR_NOP;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/id_stage_grf.sv
// 32x32 general register file: two combinational read ports, one write port, $0 hardwired to zero.
// Define ID_WB_BYPASS_EN to forward the current write-back data onto matching read ports.
module id_stage_grf #(
   parameter int GRF_DEPTH = 32
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        we,
   input  logic [4:0]  a3,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   // Entry 0 has no storage; it reads as zero and swallows writes.
   logic [31:0] regs_reg [1:GRF_DEPTH-1];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 1; i < GRF_DEPTH; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (we && (a3 != 5'd0)) begin
         regs_reg[a3] <= wd;
      end
   end

   function automatic logic [31:0] read_port(input logic [4:0] ra);
      logic [31:0] value;
      value = (ra == 5'd0) ? 32'd0 : regs_reg[ra];
`ifdef ID_WB_BYPASS_EN
      if (we && (a3 != 5'd0) && (a3 == ra)) begin
         value = wd;
      end
`endif
      return value;
   endfunction

   always_comb begin
      rd1 = read_port(ra1);
      rd2 = read_port(ra2);
   end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, GRF, immediate extension and branch/jump resolution in ID.
// Define ID_WB_BYPASS_EN to make write-back data visible on GRF reads in the same cycle.
module id_stage #(
   parameter logic [31:0] RESET_PC  = id_stage_pkg::RESET_PC,
   parameter int          GRF_DEPTH = 32
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] IF_Instr,
   input  logic [31:0] IF_PC,
   input  logic        WB_We,
   input  logic [4:0]  WB_A3,
   input  logic [31:0] WB_WD,
   output logic [31:0] ID_Instr,
   output logic [31:0] ID_PC,
   output logic        ID_Valid,
   output logic [31:0] ID_RD1,
   output logic [31:0] ID_RD2,
   output logic [31:0] ID_Ext,
   output logic        ID_Redirect,
   output logic [31:0] ID_Target,
   output logic        ID_Link
);

   import id_stage_pkg::*;

   logic [31:0] instr_reg;
   logic [31:0] pc_reg;
   logic        valid_reg;

   // Flush shares the reset bubble and takes priority over Stall.
   always_ff @(posedge Clk) begin
      if (Rst || Flush) begin
         instr_reg <= '0;
         pc_reg    <= RESET_PC;
         valid_reg <= 1'b0;
      end else if (!Stall) begin
         instr_reg <= IF_Instr;
         pc_reg    <= IF_PC;
         valid_reg <= 1'b1;
      end
   end

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [15:0] imm;
   logic [31:0] rd1;
   logic [31:0] rd2;

   assign rs  = instr_reg[25:21];
   assign rt  = instr_reg[20:16];
   assign imm = instr_reg[15:0];

   id_stage_grf #(
      .GRF_DEPTH (GRF_DEPTH)
   ) u_grf (
      .Clk (Clk),
      .Rst (Rst),
      .we  (WB_We),
      .a3  (WB_A3),
      .wd  (WB_WD),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   instr_e      kind;
   logic        eq;
   logic        taken;
   logic [31:0] pc_plus4;
   logic [31:0] branch_off;
   logic [31:0] ext_next;
   logic [31:0] target_next;

   always_comb begin
      kind        = decode_instr(instr_reg[31:26], instr_reg[5:0]);
      eq          = (rd1 == rd2);
      pc_plus4    = pc_reg + 32'd4;
      branch_off  = {{14{imm[15]}}, imm, 2'b00};

      case (kind)
         INSTR_ORI: ext_next = {16'h0000, imm};
         INSTR_LUI: ext_next = {imm, 16'h0000};
         default:   ext_next = {{16{imm[15]}}, imm};
      endcase

      taken = 1'b0;
      target_next = pc_plus4;
      case (kind)
         INSTR_BEQ: begin
            taken       = eq;
            target_next = pc_plus4 + branch_off;
         end
         INSTR_BNE: begin
            taken       = !eq;
            target_next = pc_plus4 + branch_off;
         end
         INSTR_JAL: begin
            taken       = 1'b1;
            target_next = {pc_reg[31:28], instr_reg[25:0], 2'b00};
         end
         INSTR_JR: begin
            taken       = 1'b1;
            target_next = rd1;
         end
         default: begin
            taken       = 1'b0;
            target_next = pc_plus4;
         end
      endcase

      // Bubbles and reset must never steer fetch.
      taken = taken && valid_reg && !Rst;
      if (!taken) begin
         target_next = pc_plus4;
      end
   end

   assign ID_Instr    = instr_reg;
   assign ID_PC       = pc_reg;
   assign ID_Valid    = valid_reg;
   assign ID_RD1      = rd1;
   assign ID_RD2      = rd2;
   assign ID_Ext      = ext_next;
   assign ID_Redirect = taken;
   assign ID_Target   = target_next;
   assign ID_Link     = valid_reg && (kind == INSTR_JAL);

endmodule
